// File: rtl/fifo_halfwidth_write.sv
// rtl/fifo_halfwidth_write.sv - half-width-write / full-width-read FIFO; optional error pulses via FIFO_HALFWIDTH_WRITE_ERR_EN
module fifo_halfwidth_write #(
  parameter int WIDTH              = 32,
  parameter int DEPTH              = 32,
  parameter int TRIGGERALMOSTFULL  = 1,
  parameter int TRIGGERALMOSTEMPTY = 1,
  parameter int HALFWORDATEND      = 0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [WIDTH-1:0]               datain,
  input  logic                           write,
  input  logic                           onlyWriteHalf,
  input  logic                           read,
  output logic [WIDTH-1:0]               dataout,
  output logic [$clog2(2*DEPTH+1)-1:0]   fillLevel,
  output logic                           empty,
  output logic                           valid,
  output logic                           halfPending,
  output logic                           almostEmpty,
  output logic                           full,
  output logic                           almostFull
`ifdef FIFO_HALFWIDTH_WRITE_ERR_EN
  ,
  output logic                           overflow,
  output logic                           underflow
`endif
);

  localparam int HW  = WIDTH / 2;
  localparam int WPW = $clog2(2 * DEPTH);
  localparam int RPW = $clog2(DEPTH);
  localparam int FLW = $clog2(2 * DEPTH + 1);

  localparam logic [FLW-1:0] LVL_FULL    = FLW'(2 * DEPTH);
  localparam logic [FLW-1:0] LVL_FULL_M2 = FLW'(2 * DEPTH - 2);
  localparam logic [FLW-1:0] LVL_TWO     = FLW'(2);
  localparam logic [FLW-1:0] LVL_ONE     = FLW'(1);

  // Two half-width banks: even half-word slots live in lo, odd slots in hi.
  logic [HW-1:0] lo_q [DEPTH];
  logic [HW-1:0] hi_q [DEPTH];

  logic [WPW-1:0] wp_q, wp_d;   // write pointer in half-words
  logic [RPW-1:0] rp_q, rp_d;   // read pointer in full words
  logic [FLW-1:0] fill_q, fill_d;

  logic           wr_half, wr_full, rd_ok;
  logic [RPW-1:0] wp_addr, wp_addr_nx;
  logic           wp_odd;
  logic [HW-1:0]  half_sel;
  logic [FLW-1:0] free_slots;

  logic           lo_we, hi_we;
  logic [RPW-1:0] lo_addr, hi_addr;
  logic [HW-1:0]  lo_data, hi_data;

  // Acceptance uses only the pre-cycle level: reads and writes never credit each other.
  assign wr_half = write &  onlyWriteHalf & (fill_q <  LVL_FULL);
  assign wr_full = write & ~onlyWriteHalf & (fill_q <= LVL_FULL_M2);
  assign rd_ok   = read & (fill_q >= LVL_TWO);

  assign wp_addr    = wp_q[WPW-1:1];
  assign wp_odd     = wp_q[0];
  assign wp_addr_nx = wp_addr + RPW'(1);
  assign half_sel   = (HALFWORDATEND != 0) ? datain[WIDTH-1:HW] : datain[HW-1:0];

  // Steer write data to banks; an odd-aligned full write straddles into the next lo entry.
  always_comb begin
    lo_we   = 1'b0;
    hi_we   = 1'b0;
    lo_addr = wp_addr;
    hi_addr = wp_addr;
    lo_data = half_sel;
    hi_data = half_sel;
    if (!reset) begin
      if (wr_half) begin
        if (wp_odd) begin
          hi_we = 1'b1;
        end else begin
          lo_we = 1'b1;
        end
      end else if (wr_full) begin
        lo_we = 1'b1;
        hi_we = 1'b1;
        if (wp_odd) begin
          hi_data = datain[HW-1:0];
          lo_data = datain[WIDTH-1:HW];
          lo_addr = wp_addr_nx;
        end else begin
          lo_data = datain[HW-1:0];
          hi_data = datain[WIDTH-1:HW];
        end
      end
    end
  end

  // Bank storage carries no reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (lo_we) lo_q[lo_addr] <= lo_data;
    if (hi_we) hi_q[hi_addr] <= hi_data;
  end

  // Next-state pointers and level.
  always_comb begin
    wp_d   = wp_q;
    rp_d   = rp_q;
    fill_d = fill_q;
    if (wr_full) begin
      wp_d = wp_q + WPW'(2);
    end else if (wr_half) begin
      wp_d = wp_q + WPW'(1);
    end
    if (rd_ok) begin
      rp_d = rp_q + RPW'(1);
    end
    fill_d = fill_q - (rd_ok ? LVL_TWO : '0)
                    + (wr_full ? LVL_TWO : (wr_half ? LVL_ONE : '0));
  end

  // Pointer and level registers; reset discards any pending half-word.
  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q   <= '0;
      rp_q   <= '0;
      fill_q <= '0;
    end else begin
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      fill_q <= fill_d;
    end
  end

`ifdef FIFO_HALFWIDTH_WRITE_ERR_EN
  logic overflow_q, underflow_q;

  // One-cycle pulses for rejected writes and reads (read at level 1 counts as rejected).
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= write & ~(wr_half | wr_full);
      underflow_q <= read & ~rd_ok;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

  assign free_slots  = LVL_FULL - fill_q;
  assign dataout     = {hi_q[rp_q], lo_q[rp_q]};
  assign fillLevel   = fill_q;
  assign empty       = (fill_q == '0);
  assign valid       = (fill_q >= LVL_TWO);
  assign halfPending = fill_q[0];
  assign full        = (fill_q == LVL_FULL);
  assign almostFull  = (int'(free_slots) <= 2 * TRIGGERALMOSTFULL);
  assign almostEmpty = (int'(fill_q >> 1) < TRIGGERALMOSTEMPTY);

endmodule
